// File: rtl/mesi_pkg.sv
// Shared MESI encodings and snoop FSM state type used by both halves of the
// coherence controller (snoop responder and CPU-side next-state machine).
package mesi_pkg;

    localparam logic [2:0] ST_INVALID   = 3'b000;
    localparam logic [2:0] ST_MODIFIED  = 3'b001;
    localparam logic [2:0] ST_SHARED    = 3'b010;
    localparam logic [2:0] ST_EXCLUSIVE = 3'b011;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_RMISS = 2'b01;
    localparam logic [1:0] OP_WMISS = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    typedef enum logic [1:0] {
        SN_IDLE,
        SN_LOOKUP,
        SN_WRITEBACK,
        SN_RESPOND
    } snoop_state_t;

    // Unused codes collapse to INVALID so nothing downstream sees them.
    function automatic logic [2:0] norm_state(input logic [2:0] s);
        case (s)
            ST_MODIFIED, ST_SHARED, ST_EXCLUSIVE: norm_state = s;
            default:                              norm_state = ST_INVALID;
        endcase
    endfunction

    function automatic logic line_valid(input logic [2:0] s);
        line_valid = (norm_state(s) != ST_INVALID);
    endfunction

endpackage

// File: rtl/mesi_line_array.sv
// Per-line tag/MESI state storage: combinational lookup and CPU read ports,
// with the snoop write taking priority over a CPU write to the same line.
module mesi_line_array
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] lk_index,
    output logic [2:0]       lk_state,
    output logic [TAG_W-1:0] lk_tag,
    input  logic [IDX_W-1:0] rd_index,
    output logic [2:0]       rd_state,
    output logic [TAG_W-1:0] rd_tag,
    input  logic             snp_we,
    input  logic [IDX_W-1:0] snp_index,
    input  logic [2:0]       snp_state,
    input  logic             cpu_we,
    input  logic [IDX_W-1:0] cpu_index,
    input  logic [TAG_W-1:0] cpu_tag,
    input  logic [2:0]       cpu_state
);

    logic [2:0]       state_reg [NUM_LINES];
    logic [TAG_W-1:0] tag_reg   [NUM_LINES];

    // Snoop writes only change state; the tag belongs to whoever filled the line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_reg[i] <= ST_INVALID;
                tag_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (snp_we && snp_index == IDX_W'(i)) begin
                    state_reg[i] <= snp_state;
                end else if (cpu_we && cpu_index == IDX_W'(i)) begin
                    state_reg[i] <= norm_state(cpu_state);
                    tag_reg[i]   <= cpu_tag;
                end
            end
        end
    end

    assign lk_state = state_reg[lk_index];
    assign lk_tag   = tag_reg[lk_index];
    assign rd_state = state_reg[rd_index];
    assign rd_tag   = tag_reg[rd_index];

endmodule

// File: rtl/mesi_snoop_responder.sv
// Bus-side MESI snoop responder: looks up snooped requests, downgrades or
// invalidates the line, writes back Modified data and reports sharing.
module mesi_snoop_responder
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bus_valid,
    output logic             bus_ready,
    input  logic [1:0]       bus_op,
    input  logic [IDX_W-1:0] bus_index,
    input  logic [TAG_W-1:0] bus_tag,
    output logic             snoop_done,
    output logic             shared,
    output logic             wb_req,
    output logic [IDX_W-1:0] wb_index,
    output logic [TAG_W-1:0] wb_tag,
    input  logic             wb_ack,
    input  logic             cpu_upd_valid,
    output logic             cpu_upd_ready,
    input  logic [IDX_W-1:0] cpu_upd_index,
    input  logic [TAG_W-1:0] cpu_upd_tag,
    input  logic [2:0]       cpu_upd_state,
    input  logic [IDX_W-1:0] cpu_rd_index,
    output logic [2:0]       cpu_rd_state,
    output logic [TAG_W-1:0] cpu_rd_tag
);

    snoop_state_t     state_reg, state_next;
    logic [1:0]       op_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [TAG_W-1:0] req_tag_reg;
    logic             hit_reg;
    logic [2:0]       new_state_reg;
    logic [IDX_W-1:0] wb_index_reg;
    logic [TAG_W-1:0] wb_tag_reg;

    logic [2:0]       lk_state;
    logic [TAG_W-1:0] lk_tag;
    logic             hit;
    logic [2:0]       new_state;
    logic             accept;
    logic             snp_we;
    logic             cpu_we;

    mesi_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .lk_index  (idx_reg),
        .lk_state  (lk_state),
        .lk_tag    (lk_tag),
        .rd_index  (cpu_rd_index),
        .rd_state  (cpu_rd_state),
        .rd_tag    (cpu_rd_tag),
        .snp_we    (snp_we),
        .snp_index (idx_reg),
        .snp_state (new_state_reg),
        .cpu_we    (cpu_we),
        .cpu_index (cpu_upd_index),
        .cpu_tag   (cpu_upd_tag),
        .cpu_state (cpu_upd_state)
    );

    assign hit = line_valid(lk_state) && (lk_tag == req_tag_reg);

    always_comb begin
        new_state = norm_state(lk_state);
        if (hit) begin
            case (op_reg)
                OP_RMISS:        new_state = ST_SHARED;
                OP_WMISS, OP_INV: new_state = ST_INVALID;
                default:         new_state = norm_state(lk_state);
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus_ready     = 1'b0;
        snoop_done    = 1'b0;
        shared        = 1'b0;
        wb_req        = 1'b0;
        cpu_upd_ready = 1'b1;
        snp_we        = 1'b0;
        accept        = 1'b0;
        case (state_reg)
            SN_IDLE: begin
                bus_ready = 1'b1;
                accept    = bus_valid;
                if (bus_valid) state_next = SN_LOOKUP;
            end
            SN_LOOKUP: begin
                cpu_upd_ready = (cpu_upd_index != idx_reg);
                state_next    = (hit && norm_state(lk_state) == ST_MODIFIED) ? SN_WRITEBACK : SN_RESPOND;
            end
            SN_WRITEBACK: begin
                cpu_upd_ready = (cpu_upd_index != idx_reg);
                wb_req        = 1'b1;
                if (wb_ack) state_next = SN_RESPOND;
            end
            SN_RESPOND: begin
                cpu_upd_ready = (cpu_upd_index != idx_reg);
                snoop_done    = 1'b1;
                shared        = hit_reg && (op_reg == OP_RMISS);
                snp_we        = hit_reg;
                state_next    = SN_IDLE;
            end
            default: state_next = SN_IDLE;
        endcase
    end

    assign cpu_we   = cpu_upd_valid && cpu_upd_ready;
    assign wb_index = wb_index_reg;
    assign wb_tag   = wb_tag_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= SN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Lookup result is frozen here so the RESPOND write is immune to
    // CPU traffic on other lines in the meantime.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_reg        <= OP_NONE;
            idx_reg       <= '0;
            req_tag_reg   <= '0;
            hit_reg       <= 1'b0;
            new_state_reg <= ST_INVALID;
            wb_index_reg  <= '0;
            wb_tag_reg    <= '0;
        end else begin
            if (accept) begin
                op_reg      <= bus_op;
                idx_reg     <= bus_index;
                req_tag_reg <= bus_tag;
            end
            if (state_reg == SN_LOOKUP) begin
                hit_reg       <= hit;
                new_state_reg <= new_state;
                if (hit && norm_state(lk_state) == ST_MODIFIED) begin
                    wb_index_reg <= idx_reg;
                    wb_tag_reg   <= lk_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for the MESI snoop responder: a transaction-level model of
// the line array and snoop timing is compared against the DUT every cycle.
module tb_mesi_snoop_responder;

    localparam logic [2:0] S_I = 3'b000, S_M = 3'b001, S_S = 3'b010, S_E = 3'b011;
    localparam logic [1:0] O_NONE = 2'b00, O_RM = 2'b01, O_WM = 2'b10, O_INV = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bus_valid = 1'b0;
    logic       bus_ready;
    logic [1:0] bus_op = 2'b00;
    logic [1:0] bus_index = 2'd0;
    logic [7:0] bus_tag = 8'h00;
    logic       snoop_done, shared, wb_req;
    logic [1:0] wb_index;
    logic [7:0] wb_tag;
    logic       wb_ack = 1'b0;
    logic       cpu_upd_valid = 1'b0;
    logic       cpu_upd_ready;
    logic [1:0] cpu_upd_index = 2'd0;
    logic [7:0] cpu_upd_tag = 8'h00;
    logic [2:0] cpu_upd_state = 3'b000;
    logic [1:0] cpu_rd_index = 2'd0;
    logic [2:0] cpu_rd_state;
    logic [7:0] cpu_rd_tag;

    int vectors = 0;
    int miscompares = 0;

    mesi_snoop_responder #(.NUM_LINES(4), .IDX_W(2), .TAG_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_op        (bus_op),
        .bus_index     (bus_index),
        .bus_tag       (bus_tag),
        .snoop_done    (snoop_done),
        .shared        (shared),
        .wb_req        (wb_req),
        .wb_index      (wb_index),
        .wb_tag        (wb_tag),
        .wb_ack        (wb_ack),
        .cpu_upd_valid (cpu_upd_valid),
        .cpu_upd_ready (cpu_upd_ready),
        .cpu_upd_index (cpu_upd_index),
        .cpu_upd_tag   (cpu_upd_tag),
        .cpu_upd_state (cpu_upd_state),
        .cpu_rd_index  (cpu_rd_index),
        .cpu_rd_state  (cpu_rd_state),
        .cpu_rd_tag    (cpu_rd_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [2:0] ms [4];
    logic [7:0] mt [4];
    bit         active = 0;
    bit         was_active;
    bit         cpu_ok;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         done_cyc = -1;
    bit         need_wb = 0;
    bit         exp_sh = 0;
    bit         m_commit = 0;
    bit         m_hit;
    logic [1:0] m_idx = 2'd0;
    logic [7:0] m_wbtag = 8'h00;
    logic [2:0] m_new = 3'b000;

    function automatic logic [2:0] mnorm(input logic [2:0] s);
        return (s == S_M || s == S_S || s == S_E) ? s : S_I;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin ms[i] = S_I; mt[i] = 8'h00; end
            active = 0;
        end else begin
            cyc++;
            was_active = active;
            cpu_ok = !(was_active && cpu_upd_index == m_idx);
            if (was_active && need_wb && done_cyc < 0 && (cyc - 1) >= acc_cyc + 1 && wb_ack)
                done_cyc = cyc;
            if (was_active && done_cyc == cyc - 1) begin
                if (m_commit) ms[m_idx] = m_new;
                active = 0;
            end
            if (cpu_upd_valid && cpu_ok) begin
                ms[cpu_upd_index] = mnorm(cpu_upd_state);
                mt[cpu_upd_index] = cpu_upd_tag;
            end
            if (!was_active && bus_valid) begin
                active   = 1;
                acc_cyc  = cyc;
                m_idx    = bus_index;
                m_hit    = (ms[bus_index] != S_I) && (mt[bus_index] == bus_tag);
                need_wb  = m_hit && ms[bus_index] == S_M;
                m_wbtag  = mt[bus_index];
                exp_sh   = m_hit && bus_op == O_RM;
                m_commit = m_hit && bus_op != O_NONE;
                m_new    = (bus_op == O_RM) ? S_S : S_I;
                done_cyc = need_wb ? -1 : cyc + 1;
            end
        end
    end

    bit exp_done, exp_wb;
    always @(negedge clock) begin
        if (!reset) begin
            exp_done = active && cyc == done_cyc;
            exp_wb   = active && need_wb && done_cyc < 0 && cyc >= acc_cyc + 1;
            check("bus_ready", bus_ready, !active);
            check("snoop_done", snoop_done, exp_done);
            check("shared", shared, exp_done && exp_sh);
            check("wb_req", wb_req, exp_wb);
            if (exp_wb) begin
                check("wb_index", wb_index, m_idx);
                check("wb_tag", wb_tag, m_wbtag);
            end
            check("cpu_upd_ready", cpu_upd_ready, !(active && cpu_upd_index == m_idx));
            check("cpu_rd_state", cpu_rd_state, ms[cpu_rd_index]);
            check("cpu_rd_tag", cpu_rd_tag, mt[cpu_rd_index]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] idx, input logic [7:0] tag, input logic [2:0] st);
        cpu_upd_valid = 1'b1; cpu_upd_index = idx; cpu_upd_tag = tag; cpu_upd_state = st;
        tick();
        cpu_upd_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] idx, input logic [7:0] tag);
        bus_valid = 1'b1; bus_op = op; bus_index = idx; bus_tag = tag;
        tick();
        bus_valid = 1'b0;
    endtask

    // Waits out the write-back, acking once wb_req has been seen ack_after times.
    task automatic wb_handshake(input int ack_after, input logic [1:0] eidx,
                                input logic [7:0] etag, output int cnt);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (snoop_done) break;
            if (wb_req) begin
                cnt++;
                check("wb_index_lit", wb_index, eidx);
                check("wb_tag_lit", wb_tag, etag);
                if (cnt == ack_after) wb_ack = 1'b1;
            end
            tick();
            wb_ack = 1'b0;
        end
        check("wb_done_reached", snoop_done, 1);
    endtask

    task automatic read_line(input logic [1:0] idx, input logic [2:0] est, input logic [7:0] etag,
                             input string name);
        cpu_rd_index = idx;
        #1;
        check(name, {cpu_rd_tag, 5'd0, cpu_rd_state}, {etag, 5'd0, est});
    endtask

    int cnt;

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_bus_ready", bus_ready, 1);
        check("rst_wb_req", wb_req, 0);
        check("rst_snoop_done", snoop_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) read_line(2'(i), S_I, 8'h00, "rst_line");

        // Fill lines
        cpu_write(2'd1, 8'h3A, S_E);
        cpu_write(2'd2, 8'h55, S_M);
        cpu_write(2'd0, 8'h12, S_S);
        cpu_write(2'd3, 8'h77, S_S);

        // readMiss hit on EXCLUSIVE -> SHARED, shared=1, no write-back
        issue(O_RM, 2'd1, 8'h3A);
        check("rm_lookup_no_done", snoop_done, 0);
        tick();
        check("rm_done_t2", snoop_done, 1);
        check("rm_shared", shared, 1);
        check("rm_no_wb", wb_req, 0);
        tick();
        read_line(2'd1, S_S, 8'h3A, "rm_line1");
        $display("txn readMiss idx1 tag3A done shared=1");

        // stray ack while idle is ignored
        wb_ack = 1'b1; tick(); wb_ack = 1'b0;

        // writeMiss on MODIFIED with 3-cycle write-back
        issue(O_WM, 2'd2, 8'h55);
        wb_handshake(3, 2'd2, 8'h55, cnt);
        check("wm_wb_cycles", cnt, 3);
        check("wm_shared", shared, 0);
        tick();
        read_line(2'd2, S_I, 8'h55, "wm_line2");
        $display("txn writeMiss idx2 tag55 done wb_cycles=%0d", cnt);

        // readMiss tag mismatch: line untouched
        issue(O_RM, 2'd0, 8'h11);
        tick();
        check("miss_done", snoop_done, 1);
        check("miss_shared", shared, 0);
        tick();
        read_line(2'd0, S_S, 8'h12, "miss_line0");
        $display("txn readMiss idx0 tag11 done shared=0");

        // invalidate idx3 with conflicting and non-conflicting CPU updates
        issue(O_INV, 2'd3, 8'h77);
        cpu_upd_valid = 1'b1; cpu_upd_index = 2'd3; cpu_upd_tag = 8'h99; cpu_upd_state = S_M;
        #1;
        check("inv_upd_blocked_lookup", cpu_upd_ready, 0);
        tick();
        check("inv_done", snoop_done, 1);
        check("inv_upd_blocked_respond", cpu_upd_ready, 0);
        cpu_upd_index = 2'd0; cpu_upd_tag = 8'h21; cpu_upd_state = S_E;
        #1;
        check("inv_other_upd_ready", cpu_upd_ready, 1);
        tick();
        cpu_upd_valid = 1'b0;
        read_line(2'd3, S_I, 8'h77, "inv_line3");
        read_line(2'd0, S_E, 8'h21, "inv_line0");
        $display("txn invalidate idx3 tag77 done");

        // same-cycle CPU update and acceptance: lookup sees MODIFIED
        cpu_upd_valid = 1'b1; cpu_upd_index = 2'd1; cpu_upd_tag = 8'h3A; cpu_upd_state = S_M;
        issue(O_RM, 2'd1, 8'h3A);
        cpu_upd_valid = 1'b0;
        wb_handshake(1, 2'd1, 8'h3A, cnt);
        check("same_cyc_wb_cycles", cnt, 1);
        check("same_cyc_shared", shared, 1);
        tick();
        read_line(2'd1, S_S, 8'h3A, "same_cyc_line1");
        $display("txn readMiss idx1 tag3A (after CPU M) done wb_cycles=%0d", cnt);

        // reset while in WRITEBACK
        cpu_write(2'd2, 8'h55, S_M);
        issue(O_WM, 2'd2, 8'h55);
        tick();
        check("rst_wb_active", wb_req, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_wb_req", wb_req, 0);
        check("rst_async_done", snoop_done, 0);
        check("rst_async_ready", bus_ready, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) read_line(2'(i), S_I, 8'h00, "rst_mid_line");
        repeat (3) tick();
        $display("txn writeMiss idx2 aborted by reset");

        // held bus_valid: op 00 then readMiss back to back
        cpu_write(2'd0, 8'h21, S_E);
        bus_valid = 1'b1; bus_op = O_NONE; bus_index = 2'd0; bus_tag = 8'h21;
        tick();
        tick();
        check("nop_done", snoop_done, 1);
        check("nop_shared", shared, 0);
        check("nop_not_ready", bus_ready, 0);
        bus_op = O_RM;
        tick();
        check("b2b_ready_after_done", bus_ready, 1);
        read_line(2'd0, S_E, 8'h21, "nop_line0");
        tick();
        bus_valid = 1'b0;
        check("b2b_accepted", bus_ready, 0);
        tick();
        check("b2b_done", snoop_done, 1);
        check("b2b_shared", shared, 1);
        tick();
        read_line(2'd0, S_S, 8'h21, "b2b_line0");
        $display("txn op00 idx0 + readMiss idx0 back-to-back done");

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
